// File: rtl/event_read_sequencer.sv
// event_read_sequencer: counts events completed across N_CH ring-buffer
// writers and reads each event back channel by channel, one beat per
// accepted rd_ready. Also provides partial-event timeout diagnosis and
// protection against too many pending events.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no read in flight; waits for a pending event and no timeout
// S_READ | streaming beats of the current event, channel by channel
module event_read_sequencer #(
    parameter int N_CH             = 16,
    parameter int ADDR_W           = 15,
    parameter int LEN_W            = 10,
    parameter int CNT_W            = 16,
    parameter int MAX_PENDING      = 16,
    parameter int MAX_WAITING_TIME = 1000,
    localparam int CH_W            = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              live_rising,
    input  logic [LEN_W-1:0]  half_package_length,
    input  logic [ADDR_W-1:0] memory_depth,
    input  logic [N_CH-1:0]   input_ena,
    input  logic [N_CH-1:0]   w_complete,
    input  logic              rd_ready,
    input  logic              skip_disabled,
    input  logic              timeout_clear,
    output logic              ren,
    output logic [ADDR_W-1:0] raddr,
    output logic [CH_W-1:0]   read_input_id,
    output logic              rd_first,
    output logic              rd_last,
    output logic [CNT_W-1:0]  n_write,
    output logic [CNT_W-1:0]  n_read,
    output logic [CNT_W-1:0]  pending,
    output logic              timeout,
    output logic [N_CH-1:0]   timeout_mask,
    output logic              overflow
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    localparam int TC_W  = $clog2(MAX_WAITING_TIME + 1);
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;
    localparam logic [CNT_W-1:0] MAX_PEND_C = CNT_W'(MAX_PENDING);
    localparam logic [TC_W-1:0]  MWT_C      = TC_W'(MAX_WAITING_TIME);

    state_t            state_q, state_d;
    logic [N_CH-1:0]   w_tag_q, w_tag_d;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;
    logic              timeout_q, timeout_d;
    logic [N_CH-1:0]   timeout_mask_q, timeout_mask_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  n_write_q, n_write_d;
    logic [CNT_W-1:0]  n_read_q, n_read_d;
    logic [CNT_W-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]   ena_r_q, ena_r_d;
    logic [LEN_W-1:0]  len_r_q, len_r_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [CH_W-1:0]   id_q, id_d;
    logic              ren_q, ren_d;
    logic              rd_first_q, rd_first_d;
    logic              rd_last_q, rd_last_d;

    logic [N_CH-1:0]   hit;
    logic              wr_done;
    logic [N_CH-1:0]   ena_pick;
    logic [LEN_W-1:0]  len_pick;
    logic [CH_W:0]     first_ch;
    logic [CH_W:0]     nxt_ch;
    logic [CH_W:0]     after_ch;
    logic [SUM_W-1:0]  init_sum;

    // Lowest set bit of mask at or above index start; MSB of result = found.
    function automatic logic [CH_W:0] find_from(input logic [N_CH-1:0] mask,
                                                input int start);
        logic [CH_W:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= start)) begin
                r = {1'b1, i[CH_W-1:0]};
            end
        end
        return r;
    endfunction

    // Next-state logic: write tracking, timeout/overflow, and the read FSM.
    always_comb begin
        state_d        = state_q;
        w_tag_d        = w_tag_q;
        tcnt_d         = tcnt_q;
        timeout_d      = timeout_q;
        timeout_mask_d = timeout_mask_q;
        overflow_d     = overflow_q;
        n_write_d      = n_write_q;
        n_read_d       = n_read_q;
        ena_r_d        = ena_r_q;
        len_r_d        = len_r_q;
        beat_d         = beat_q;
        init_addr_d    = init_addr_q;
        raddr_d        = raddr_q;
        id_d           = id_q;
        ren_d          = ren_q;
        rd_first_d     = rd_first_q;
        rd_last_d      = rd_last_q;
        ena_pick       = '0;
        len_pick       = '0;
        first_ch       = '0;
        nxt_ch         = '0;
        after_ch       = '0;
        init_sum       = '0;

        // w_complete bits arriving in the completing cycle belong to that event
        hit     = (w_tag_q | w_complete) & input_ena;
        wr_done = (input_ena != '0) && (hit == input_ena);
        w_tag_d = wr_done ? '0 : hit;

        if (wr_done) begin
            if (pending_q == MAX_PEND_C) begin
                overflow_d = 1'b1;
            end else begin
                n_write_d = n_write_q + CNT_W'(1);
            end
        end

        // Counter freezes once timeout is flagged so the diagnosis stays put
        if (!timeout_q) begin
            if (w_tag_q == '0) begin
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + TC_W'(1);
                if (tcnt_d == MWT_C) begin
                    timeout_d      = 1'b1;
                    timeout_mask_d = input_ena & ~w_tag_q;
                end
            end
        end

        if (timeout_clear) begin
            timeout_d      = 1'b0;
            timeout_mask_d = '0;
            overflow_d     = 1'b0;
            w_tag_d        = '0;
            tcnt_d         = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (!timeout_q && (pending_q != '0)) begin
                    ena_pick = skip_disabled ? input_ena : '1;
                    // An empty mask would leave no channel to read; read all
                    if (ena_pick == '0) begin
                        ena_pick = '1;
                    end
                    len_pick = (half_package_length == '0) ? LEN_W'(1)
                                                           : half_package_length;
                    first_ch    = find_from(ena_pick, 0);
                    nxt_ch      = find_from(ena_pick, int'(first_ch[CH_W-1:0]) + 1);
                    ena_r_d     = ena_pick;
                    len_r_d     = len_pick;
                    raddr_d     = init_addr_q;
                    id_d        = first_ch[CH_W-1:0];
                    ren_d       = 1'b1;
                    beat_d      = '0;
                    rd_first_d  = 1'b1;
                    rd_last_d   = (len_pick == LEN_W'(1)) && !nxt_ch[CH_W];
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                if (ren_q && rd_ready) begin
                    nxt_ch     = find_from(ena_r_q, int'(id_q) + 1);
                    rd_first_d = 1'b0;
                    if (beat_q < (len_r_q - LEN_W'(1))) begin
                        beat_d    = beat_q + LEN_W'(1);
                        raddr_d   = (raddr_q == (memory_depth - ADDR_W'(1)))
                                    ? '0 : raddr_q + ADDR_W'(1);
                        rd_last_d = (beat_d == (len_r_q - LEN_W'(1))) && !nxt_ch[CH_W];
                    end else if (nxt_ch[CH_W]) begin
                        after_ch  = find_from(ena_r_q, int'(nxt_ch[CH_W-1:0]) + 1);
                        id_d      = nxt_ch[CH_W-1:0];
                        raddr_d   = init_addr_q;
                        beat_d    = '0;
                        rd_last_d = (len_r_q == LEN_W'(1)) && !after_ch[CH_W];
                    end else begin
                        ren_d     = 1'b0;
                        rd_last_d = 1'b0;
                        n_read_d  = n_read_q + CNT_W'(1);
                        init_sum  = SUM_W'(init_addr_q) + SUM_W'(len_r_q);
                        if (init_sum >= SUM_W'(memory_depth)) begin
                            init_addr_d = ADDR_W'(init_sum - SUM_W'(memory_depth));
                        end else begin
                            init_addr_d = ADDR_W'(init_sum);
                        end
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registers, with synchronous reset abandoning any read in flight.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            state_q        <= S_IDLE;
            w_tag_q        <= '0;
            tcnt_q         <= '0;
            timeout_q      <= 1'b0;
            timeout_mask_q <= '0;
            overflow_q     <= 1'b0;
            n_write_q      <= '0;
            n_read_q       <= '0;
            pending_q      <= '0;
            ena_r_q        <= '0;
            len_r_q        <= '0;
            beat_q         <= '0;
            init_addr_q    <= '0;
            raddr_q        <= '0;
            id_q           <= '0;
            ren_q          <= 1'b0;
            rd_first_q     <= 1'b0;
            rd_last_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            w_tag_q        <= w_tag_d;
            tcnt_q         <= tcnt_d;
            timeout_q      <= timeout_d;
            timeout_mask_q <= timeout_mask_d;
            overflow_q     <= overflow_d;
            n_write_q      <= n_write_d;
            n_read_q       <= n_read_d;
            pending_q      <= pending_d;
            ena_r_q        <= ena_r_d;
            len_r_q        <= len_r_d;
            beat_q         <= beat_d;
            init_addr_q    <= init_addr_d;
            raddr_q        <= raddr_d;
            id_q           <= id_d;
            ren_q          <= ren_d;
            rd_first_q     <= rd_first_d;
            rd_last_q      <= rd_last_d;
        end
    end

    assign pending_d     = n_write_d - n_read_d;

    assign ren           = ren_q;
    assign raddr         = raddr_q;
    assign read_input_id = id_q;
    assign rd_first      = rd_first_q;
    assign rd_last       = rd_last_q;
    assign n_write       = n_write_q;
    assign n_read        = n_read_q;
    assign pending       = pending_q;
    assign timeout       = timeout_q;
    assign timeout_mask  = timeout_mask_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_event_read_sequencer.sv
// Testbench for event_read_sequencer: table of read scenarios plus
// hand-written timeout, overflow and mid-read reset sequences.
module tb_event_read_sequencer;

    localparam int N_CH   = 16;
    localparam int ADDR_W = 15;
    localparam int LEN_W  = 10;
    localparam int CNT_W  = 16;
    localparam int CH_W   = 4;

    logic              clk = 1'b0;
    logic              live_rising;
    logic [LEN_W-1:0]  half_package_length;
    logic [ADDR_W-1:0] memory_depth;
    logic [N_CH-1:0]   input_ena;
    logic [N_CH-1:0]   w_complete;
    logic              rd_ready;
    logic              skip_disabled;
    logic              timeout_clear;
    logic              ren;
    logic [ADDR_W-1:0] raddr;
    logic [CH_W-1:0]   read_input_id;
    logic              rd_first;
    logic              rd_last;
    logic [CNT_W-1:0]  n_write;
    logic [CNT_W-1:0]  n_read;
    logic [CNT_W-1:0]  pending;
    logic              timeout;
    logic [N_CH-1:0]   timeout_mask;
    logic              overflow;

    always #5 clk = ~clk;

    event_read_sequencer #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W),
        .MAX_PENDING(2), .MAX_WAITING_TIME(10)
    ) dut (
        .clk(clk), .live_rising(live_rising),
        .half_package_length(half_package_length), .memory_depth(memory_depth),
        .input_ena(input_ena), .w_complete(w_complete), .rd_ready(rd_ready),
        .skip_disabled(skip_disabled), .timeout_clear(timeout_clear),
        .ren(ren), .raddr(raddr), .read_input_id(read_input_id),
        .rd_first(rd_first), .rd_last(rd_last), .n_write(n_write),
        .n_read(n_read), .pending(pending), .timeout(timeout),
        .timeout_mask(timeout_mask), .overflow(overflow)
    );

    typedef struct {
        logic [15:0] ena;
        logic        skip;
        logic [9:0]  len;
        logic [14:0] depth;
        int          events;
        int          stall_at;
        int          exp_beats;
        logic [14:0] exp_last_addr;
    } vec_t;

    vec_t tbl[8];
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        live_rising = 1'b1;
        repeat (2) @(negedge clk);
        live_rising = 1'b0;
    endtask

    task automatic pulse_wc(input logic [15:0] m);
        w_complete = m;
        @(negedge clk);
        w_complete = '0;
    endtask

    task automatic check_beat(input int b, input int ch, input int addr, input int total);
        check($sformatf("beat%0d_ren", b), 32'(ren), 1);
        check($sformatf("beat%0d_id", b), 32'(read_input_id), ch);
        check($sformatf("beat%0d_addr", b), 32'(raddr), addr);
        check($sformatf("beat%0d_first", b), 32'(rd_first), 32'(b == 0));
        check($sformatf("beat%0d_last", b), 32'(rd_last), 32'(b == total - 1));
    endtask

    // Reads one event and checks every beat against the channel/address model.
    task automatic read_event(input logic [15:0] rmask, input int lr, input int depth,
                              input int stall_at, input int init_in,
                              output int init_out, output int nbeats,
                              output logic [14:0] last_addr);
        int ids[$];
        int waited;
        int total;
        nbeats    = 0;
        last_addr = '0;
        init_out  = init_in;
        rd_ready  = 1'b1;
        for (int c = 0; c < 16; c++) if (rmask[c]) ids.push_back(c);
        waited = 0;
        while (ren !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ren_start", 32'(ren), 1);
        if (ren !== 1'b1) return;
        total = ids.size() * lr;
        for (int b = 0; b < total; b++) begin
            check_beat(b, ids[b / lr], (init_in + b % lr) % depth, total);
            if (ren === 1'b1) nbeats++;
            last_addr = raddr;
            if (b == stall_at) begin
                rd_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    check_beat(b, ids[b / lr], (init_in + b % lr) % depth, total);
                end
                rd_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("ren_gap", 32'(ren), 0);
        init_out = (init_in + lr) % depth;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int init;
        int nb;
        int total_beats;
        int lr;
        logic [15:0] rmask;
        logic [14:0] la;
        logic [14:0] last_seen;

        tbl[0] = '{16'hFFFF, 1'b0, 10'd4, 15'd64, 1, -1,  64, 15'd3};
        tbl[1] = '{16'hFFFF, 1'b0, 10'd4, 15'd6,  3, -1, 192, 15'd5};
        tbl[2] = '{16'h0005, 1'b1, 10'd4, 15'd64, 1, -1,   8, 15'd3};
        tbl[3] = '{16'h0005, 1'b0, 10'd4, 15'd64, 1, -1,  64, 15'd3};
        tbl[4] = '{16'h0003, 1'b1, 10'd4, 15'd64, 1,  1,   8, 15'd3};
        tbl[5] = '{16'h0003, 1'b1, 10'd0, 15'd64, 2,  1,   4, 15'd1};
        tbl[6] = '{16'h8001, 1'b1, 10'd3, 15'd5,  2,  2,  12, 15'd0};
        tbl[7] = '{16'h0003, 1'b1, 10'd4, 15'd64, 1,  7,   8, 15'd3};

        live_rising = 1'b1;
        half_package_length = 10'd4;
        memory_depth = 15'd64;
        input_ena = '0;
        w_complete = '0;
        rd_ready = 1'b0;
        skip_disabled = 1'b0;
        timeout_clear = 1'b0;
        repeat (3) @(negedge clk);
        live_rising = 1'b0;

        check("rst_ren", 32'(ren), 0);
        check("rst_raddr", 32'(raddr), 0);
        check("rst_id", 32'(read_input_id), 0);
        check("rst_first", 32'(rd_first), 0);
        check("rst_last", 32'(rd_last), 0);
        check("rst_n_write", 32'(n_write), 0);
        check("rst_n_read", 32'(n_read), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_mask", 32'(timeout_mask), 0);
        check("rst_overflow", 32'(overflow), 0);

        for (int s = 0; s < 8; s++) begin
            do_reset();
            input_ena = tbl[s].ena;
            skip_disabled = tbl[s].skip;
            half_package_length = tbl[s].len;
            memory_depth = tbl[s].depth;
            rmask = tbl[s].skip ? tbl[s].ena : 16'hFFFF;
            lr = (tbl[s].len == 0) ? 1 : int'(tbl[s].len);
            init = 0;
            total_beats = 0;
            last_seen = '0;
            for (int e = 0; e < tbl[s].events; e++) begin
                pulse_wc(tbl[s].ena);
                read_event(rmask, lr, int'(tbl[s].depth), tbl[s].stall_at, init, init, nb, la);
                total_beats += nb;
                last_seen = la;
            end
            check($sformatf("vec%0d_beats", s), 32'(total_beats), 32'(tbl[s].exp_beats));
            check($sformatf("vec%0d_last_addr", s), 32'(last_seen), 32'(tbl[s].exp_last_addr));
            check($sformatf("vec%0d_n_write", s), 32'(n_write), 32'(tbl[s].events));
            check($sformatf("vec%0d_n_read", s), 32'(n_read), 32'(tbl[s].events));
            check($sformatf("vec%0d_pending", s), 32'(pending), 0);
        end

        // Partial event: channels 0,1 of 0x0007 complete, channel 2 never does.
        do_reset();
        rd_ready = 1'b0;
        input_ena = 16'h0007;
        skip_disabled = 1'b1;
        half_package_length = 10'd4;
        memory_depth = 15'd64;
        pulse_wc(16'h0003);
        repeat (9) @(negedge clk);
        check("timeout_early", 32'(timeout), 0);
        @(negedge clk);
        check("timeout_set", 32'(timeout), 1);
        check("timeout_mask", 32'(timeout_mask), 32'h0004);
        check("timeout_no_read", 32'(ren), 0);
        pulse_wc(16'h0004);
        repeat (4) @(negedge clk);
        check("timeout_n_write", 32'(n_write), 1);
        check("timeout_pending", 32'(pending), 1);
        check("timeout_held_off", 32'(ren), 0);
        check("timeout_sticky", 32'(timeout), 1);
        timeout_clear = 1'b1;
        @(negedge clk);
        timeout_clear = 1'b0;
        check("clear_timeout", 32'(timeout), 0);
        check("clear_mask", 32'(timeout_mask), 0);
        check("clear_n_write", 32'(n_write), 1);
        read_event(16'h0007, 4, 64, -1, 0, init, nb, la);
        check("after_clear_beats", 32'(nb), 12);
        check("after_clear_n_read", 32'(n_read), 1);
        check("after_clear_pending", 32'(pending), 0);

        // Three events with the consumer stalled: third is dropped.
        do_reset();
        rd_ready = 1'b0;
        input_ena = 16'hFFFF;
        skip_disabled = 1'b0;
        half_package_length = 10'd1;
        memory_depth = 15'd64;
        repeat (3) begin
            pulse_wc(16'hFFFF);
            @(negedge clk);
        end
        check("ovf_n_write", 32'(n_write), 2);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_pending", 32'(pending), 2);
        check("ovf_n_read", 32'(n_read), 0);
        check("ovf_stalled_ren", 32'(ren), 1);
        read_event(16'hFFFF, 1, 64, -1, 0, init, nb, la);
        check("ovf_ev0_beats", 32'(nb), 16);
        read_event(16'hFFFF, 1, 64, -1, init, init, nb, la);
        check("ovf_ev1_beats", 32'(nb), 16);
        check("ovf_ev1_addr", 32'(la), 1);
        check("ovf_drained_pending", 32'(pending), 0);
        check("ovf_drained_n_read", 32'(n_read), 2);
        check("ovf_still_set", 32'(overflow), 1);
        timeout_clear = 1'b1;
        @(negedge clk);
        timeout_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);
        check("ovf_clear_n_write", 32'(n_write), 2);

        // Reset in the middle of a read abandons the event.
        do_reset();
        half_package_length = 10'd4;
        pulse_wc(16'hFFFF);
        rd_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_ren_before", 32'(ren), 1);
        live_rising = 1'b1;
        @(negedge clk);
        live_rising = 1'b0;
        rd_ready = 1'b0;
        check("midrst_ren", 32'(ren), 0);
        check("midrst_raddr", 32'(raddr), 0);
        check("midrst_n_write", 32'(n_write), 0);
        check("midrst_pending", 32'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
